// File: rtl/score_tracker.sv
// Score tracker: per-player and global best-score storage with a
// request/compare FSM that reports personal and global wins.
//
// Ports:
//   clk          system clock, all state updates on rising edge
//   rst          synchronous active-low reset
//   score_req    pulse: compare score against stored bests
//   newHighScore pulse: commit score to storage
//   intPlayID    player ID (0..7)
//   isGuest      current player is the guest login
//   score        final game score (unsigned, 0..127)
//   valid        one-cycle pulse qualifying personalwin/globalwin
//   personalwin  score beat this player's stored best
//   globalwin    score beat the global best
//   busy         FSM is not in IDLE
//
// Configuration macro: SCORE_TRACKER_GUEST_GLOBAL_EN
//   undefined: guests never win or update the global best
//   defined:   guests compete for the global best like any player

module score_tracker #(
    parameter logic [6:0] INIT_BEST = 7'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       score_req,
    input  logic       newHighScore,
    input  logic [2:0] intPlayID,
    input  logic       isGuest,
    input  logic [6:0] score,
    output logic       valid,
    output logic       personalwin,
    output logic       globalwin,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CMP,
        S_RESP,
        S_WRITE
    } state_t;

    state_t     r_state;
    logic [6:0] r_best [8];
    logic [6:0] r_gbest;
    logic [2:0] r_id;
    logic       r_guest;
    logic [6:0] r_score;
    logic       r_pend;
    logic [6:0] r_rd_p;
    logic [6:0] r_rd_g;
    logic       r_valid;
    logic       r_pw;
    logic       r_gw;
    logic       r_busy;
    logic       w_glob_ok;

`ifdef SCORE_TRACKER_GUEST_GLOBAL_EN
    assign w_glob_ok = 1'b1;
`else
    assign w_glob_ok = ~r_guest;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_pw    <= 1'b0;
            r_gw    <= 1'b0;
            r_busy  <= 1'b0;
            r_pend  <= 1'b0;
            r_id    <= 3'd0;
            r_guest <= 1'b0;
            r_score <= 7'd0;
            r_rd_p  <= INIT_BEST;
            r_rd_g  <= INIT_BEST;
            r_gbest <= INIT_BEST;
            for (int i = 0; i < 8; i++) begin
                r_best[i] <= INIT_BEST;
            end
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // A request deferred behind a write goes first and
                    // uses the operands latched with that write.
                    if (r_pend) begin
                        r_pend  <= 1'b0;
                        r_state <= S_READ;
                        r_busy  <= 1'b1;
                    end else if (newHighScore) begin
                        r_id    <= intPlayID;
                        r_guest <= isGuest;
                        r_score <= score;
                        r_pend  <= score_req;
                        r_state <= S_WRITE;
                        r_busy  <= 1'b1;
                    end else if (score_req) begin
                        r_id    <= intPlayID;
                        r_guest <= isGuest;
                        r_score <= score;
                        r_state <= S_READ;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    r_rd_p  <= r_best[r_id];
                    r_rd_g  <= r_gbest;
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    r_pw    <= ~r_guest && (r_score > r_rd_p);
                    r_gw    <= w_glob_ok && (r_score > r_rd_g);
                    r_valid <= 1'b1;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_WRITE: begin
                    if (!r_guest && (r_score > r_best[r_id])) begin
                        r_best[r_id] <= r_score;
                    end
                    if (w_glob_ok && (r_score > r_gbest)) begin
                        r_gbest <= r_score;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign valid       = r_valid;
    assign personalwin = r_pw;
    assign globalwin   = r_gw;
    assign busy        = r_busy;

endmodule

// File: tb/tb_score_tracker.sv
// Testbench for score_tracker: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.

module tb_score_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       score_req = 1'b0;
    logic       newHighScore = 1'b0;
    logic [2:0] intPlayID = 3'd0;
    logic       isGuest = 1'b0;
    logic [6:0] score = 7'd0;
    logic       valid;
    logic       personalwin;
    logic       globalwin;
    logic       busy;

    int checks = 0;
    int failures = 0;

    score_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .score_req    (score_req),
        .newHighScore (newHighScore),
        .intPlayID    (intPlayID),
        .isGuest      (isGuest),
        .score        (score),
        .valid        (valid),
        .personalwin  (personalwin),
        .globalwin    (globalwin),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic bit glob_ok(bit g);
`ifdef SCORE_TRACKER_GUEST_GLOBAL_EN
        return 1'b1;
`else
        return !g;
`endif
    endfunction

    // Behavioural model: tracks operations by the clock edge
    // at which they are accepted and when their effects appear.
    int         cyc = 0;
    int         busy_end = -1;
    int         resp_edge = -1;
    int         write_at = -1;
    int         pend_at = -1;
    int         next_free = 0;
    logic [6:0] m_best [8];
    logic [6:0] m_g;
    logic [2:0] l_id;
    bit         l_g;
    logic [6:0] l_s;
    bit         e_pw;
    bit         e_gw;
    bit         m_valid = 0;
    bit         m_busy = 0;
    bit         in_rst = 0;

    function automatic void accept_read(int a);
        e_pw      = !l_g && (l_s > m_best[l_id]);
        e_gw      = glob_ok(l_g) && (l_s > m_g);
        resp_edge = a + 2;
        busy_end  = a + 2;
        next_free = a + 4;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_best[i] = 7'd0;
            m_g       = 7'd0;
            busy_end  = -1;
            resp_edge = -1;
            write_at  = -1;
            pend_at   = -1;
            next_free = 0;
            in_rst    = 1;
        end else begin
            in_rst = 0;
            if (cyc == write_at) begin
                if (!l_g && l_s > m_best[l_id]) m_best[l_id] = l_s;
                if (glob_ok(l_g) && l_s > m_g) m_g = l_s;
            end
            if (cyc == pend_at) begin
                accept_read(cyc);
            end else if (cyc >= next_free) begin
                if (newHighScore) begin
                    l_id = intPlayID;
                    l_g = isGuest;
                    l_s = score;
                    write_at  = cyc + 1;
                    busy_end  = cyc;
                    next_free = cyc + 2;
                    if (score_req) pend_at = cyc + 2;
                end else if (score_req) begin
                    l_id = intPlayID;
                    l_g = isGuest;
                    l_s = score;
                    accept_read(cyc);
                end
            end
        end
        m_valid = (cyc == resp_edge);
        m_busy  = (cyc <= busy_end);
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("valid", valid, m_valid);
            chk("busy", busy, m_busy);
            if (m_valid) begin
                chk("model_personalwin", personalwin, e_pw);
                chk("model_globalwin", globalwin, e_gw);
            end
            if (in_rst) begin
                chk("rst_personalwin", personalwin, 1'b0);
                chk("rst_globalwin", globalwin, 1'b0);
            end
        end
    end

    task automatic pulse(bit rq, bit nh, logic [2:0] id,
                         bit g, logic [6:0] s);
        @(negedge clk);
        score_req    = rq;
        newHighScore = nh;
        intPlayID    = id;
        isGuest      = g;
        score        = s;
        @(negedge clk);
        score_req    = 1'b0;
        newHighScore = 1'b0;
        intPlayID    = $urandom_range(0, 7);
        score        = $urandom_range(0, 127);
        isGuest      = $urandom_range(0, 1);
    endtask

    task automatic wait_valid(string name, bit pw, bit gw);
        bit seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (valid === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_seen"}, seen, 1'b1);
        if (seen) begin
            chk({name, "_pw"}, personalwin, pw);
            chk({name, "_gw"}, globalwin, gw);
        end
    endtask

    task automatic count_valid(string name, int n, int exp);
        int cnt = 0;
        for (int k = 0; k < n; k++) begin
            if (valid === 1'b1) cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != exp) begin
            failures++;
            $display("FAIL %s: got %0d pulses expected %0d",
                     name, cnt, exp);
        end
    endtask

    initial begin
        bit gexp;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        pulse(1, 0, 3'd2, 0, 7'd5);
        wait_valid("first_req", 1, 1);

        pulse(0, 1, 3'd2, 0, 7'd40);
        pulse(1, 0, 3'd2, 0, 7'd40);
        wait_valid("equal_score", 0, 0);
        pulse(1, 0, 3'd5, 0, 7'd30);
        wait_valid("other_player", 1, 0);

        pulse(1, 1, 3'd3, 0, 7'd90);
        wait_valid("same_cycle", 0, 0);

`ifdef SCORE_TRACKER_GUEST_GLOBAL_EN
        gexp = 1;
`else
        gexp = 0;
`endif
        pulse(1, 0, 3'd3, 1, 7'd127);
        wait_valid("guest", 0, gexp);

        pulse(1, 0, 3'd1, 0, 7'd10);
        pulse(1, 0, 3'd1, 0, 7'd120);
        count_valid("busy_drop", 8, 1);

        pulse(1, 0, 3'd4, 0, 7'd100);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        count_valid("rst_abort", 6, 0);

        for (int i = 0; i < 8; i++) begin
            pulse(1, 0, 3'(i), 0, 7'd0);
            wait_valid("init_eq", 0, 0);
            pulse(1, 0, 3'(i), 0, 7'd1);
            wait_valid("init_gt", 1, 1);
        end

        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 59) != 0);
            score_req    = ($urandom_range(0, 9) < 3);
            newHighScore = ($urandom_range(0, 9) < 2);
            intPlayID    = $urandom_range(0, 7);
            isGuest      = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 0)
                score = 7'($urandom_range(0, 6) * 20);
            else
                score = $urandom_range(0, 127);
        end
        @(negedge clk);
        rst          = 1'b1;
        score_req    = 1'b0;
        newHighScore = 1'b0;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
